// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A PIC register interface: read-side FSM
// states, read-select encodings, OCW3 bit positions and the poll word layout.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRIVE   = 2'd2
  } read_state_e;

  localparam logic SEL_IRR = 1'b0;
  localparam logic SEL_ISR = 1'b1;

  localparam int OCW3_P   = 2;
  localparam int OCW3_RR  = 1;
  localparam int OCW3_RIS = 0;

  // Poll word seen by the CPU: pending flag in bit 7, level in bits 2:0.
  function automatic logic [7:0] poll_word(input logic pending, input logic [2:0] level);
    return {pending, 4'b0000, level};
  endfunction

endpackage

// File: rtl/pic_read_ctrl.sv
// CPU read-back controller: decodes OCW3 read commands and serves read cycles
// with IRR, ISR, IMR or the poll word, latched once per strobe.
module pic_read_ctrl
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_n,
  input  logic       A0,
  input  logic       write_OCW_3,
  input  logic [7:0] Internal_bus_data,
  input  logic [7:0] Interrupt_Mask,
  input  logic [7:0] Interrupt_Request_Reg,
  input  logic [7:0] In_Service_Reg,
  input  logic       interrupt_pending,
  input  logic [2:0] highest_level,
  output logic [7:0] Data_bus_out,
  output logic       Data_bus_oe,
  output logic       poll_ack
);

  read_state_e state_reg;
  logic        read_sel_reg;
  logic        poll_armed_reg;
  logic        active_prev_reg;
  logic [7:0]  data_reg;
  logic        oe_reg;
  logic        poll_ack_reg;

  logic        read_active;
  logic [7:0]  capture_word;
  logic        unused_bus_bits;

  assign read_active     = !chip_select_n && !read_n;
  assign unused_bus_bits = ^Internal_bus_data[7:3];

  always_comb begin
    capture_word = Interrupt_Request_Reg;
    if (poll_armed_reg) begin
      capture_word = poll_word(interrupt_pending, highest_level);
    end else if (A0) begin
      capture_word = Interrupt_Mask;
    end else if (read_sel_reg == SEL_ISR) begin
      capture_word = In_Service_Reg;
    end
  end

  // active_prev_reg resets high so a strobe still held across reset must be
  // released and reasserted before a new read starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      read_sel_reg    <= SEL_IRR;
      poll_armed_reg  <= 1'b0;
      active_prev_reg <= 1'b1;
      data_reg        <= 8'h00;
      oe_reg          <= 1'b0;
      poll_ack_reg    <= 1'b0;
    end else begin
      active_prev_reg <= read_active;
      poll_ack_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (read_active && !active_prev_reg) begin
            state_reg    <= CAPTURE;
            oe_reg       <= 1'b1;
            data_reg     <= capture_word;
            poll_ack_reg <= poll_armed_reg && interrupt_pending;
            if (poll_armed_reg) begin
              poll_armed_reg <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (read_active) begin
            state_reg <= DRIVE;
          end else begin
            state_reg <= IDLE;
            oe_reg    <= 1'b0;
            data_reg  <= 8'h00;
          end
        end
        DRIVE: begin
          if (!read_active) begin
            state_reg <= IDLE;
            oe_reg    <= 1'b0;
            data_reg  <= 8'h00;
          end
        end
        default: begin
          state_reg <= IDLE;
          oe_reg    <= 1'b0;
          data_reg  <= 8'h00;
        end
      endcase

      // Placed after the capture so a P=1 write on the capture edge re-arms poll.
      if (write_OCW_3) begin
        if (Internal_bus_data[OCW3_P]) begin
          poll_armed_reg <= 1'b1;
        end else if (Internal_bus_data[OCW3_RR]) begin
          read_sel_reg <= Internal_bus_data[OCW3_RIS];
        end
      end
    end
  end

  assign Data_bus_out = data_reg;
  assign Data_bus_oe  = oe_reg;
  assign poll_ack     = poll_ack_reg;

endmodule

// File: tb/tb_pic_read_ctrl.sv
// Testbench for pic_read_ctrl: directed vector table followed by random
// stimulus checked against a transaction-level reference model.
module tb_pic_read_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_select_n;
  logic       read_n;
  logic       A0;
  logic       write_OCW_3;
  logic [7:0] Internal_bus_data;
  logic [7:0] Interrupt_Mask;
  logic [7:0] Interrupt_Request_Reg;
  logic [7:0] In_Service_Reg;
  logic       interrupt_pending;
  logic [2:0] highest_level;
  logic [7:0] Data_bus_out;
  logic       Data_bus_oe;
  logic       poll_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pic_read_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .chip_select_n        (chip_select_n),
    .read_n               (read_n),
    .A0                   (A0),
    .write_OCW_3          (write_OCW_3),
    .Internal_bus_data    (Internal_bus_data),
    .Interrupt_Mask       (Interrupt_Mask),
    .Interrupt_Request_Reg(Interrupt_Request_Reg),
    .In_Service_Reg       (In_Service_Reg),
    .interrupt_pending    (interrupt_pending),
    .highest_level        (highest_level),
    .Data_bus_out         (Data_bus_out),
    .Data_bus_oe          (Data_bus_oe),
    .poll_ack             (poll_ack)
  );

  typedef struct {
    logic       rst;
    logic       cs_n;
    logic       rd_n;
    logic       a0;
    logic       wr;
    logic [7:0] ocw;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       pend;
    logic [2:0] lvl;
    logic       e_oe;
    logic [7:0] e_data;
    logic       e_ack;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, input logic cs_n, input logic rd_n, input logic a0,
                     input logic wr, input logic [7:0] ocw, input logic [7:0] irr,
                     input logic [7:0] imr, input logic pend, input logic [2:0] lvl,
                     input logic e_oe, input logic [7:0] e_data, input logic e_ack);
    vec_t v;
    v.rst = rst; v.cs_n = cs_n; v.rd_n = rd_n; v.a0 = a0; v.wr = wr; v.ocw = ocw;
    v.irr = irr; v.imr = imr; v.pend = pend; v.lvl = lvl;
    v.e_oe = e_oe; v.e_data = e_data; v.e_ack = e_ack;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %02h, expected %02h", name, idx, got, exp);
    end
  endtask

  // Reference model: a read is a transaction started by a fresh strobe; it
  // snapshots the selected word once and ends when the strobe is seen low.
  logic       m_sel, m_poll, m_reading, m_blocked, m_ack;
  logic [7:0] m_word;

  task automatic model_edge();
    logic active;
    active = !chip_select_n && !read_n;
    m_ack = 1'b0;
    if (reset) begin
      m_sel = 1'b0; m_poll = 1'b0; m_reading = 1'b0; m_blocked = 1'b1; m_word = 8'h00;
    end else begin
      if (!m_reading) begin
        if (active && !m_blocked) begin
          m_reading = 1'b1;
          if (m_poll) m_word = {interrupt_pending, 4'b0000, highest_level};
          else if (A0) m_word = Interrupt_Mask;
          else m_word = m_sel ? In_Service_Reg : Interrupt_Request_Reg;
          m_ack  = m_poll && interrupt_pending;
          m_poll = 1'b0;
        end
      end else if (!active) begin
        m_reading = 1'b0;
      end
      if (write_OCW_3) begin
        if (Internal_bus_data[2]) m_poll = 1'b1;
        else if (Internal_bus_data[1]) m_sel = Internal_bus_data[0];
      end
      m_blocked = active;
    end
  endtask

  initial begin
    int ack_in_read;
    // rst cs  rd  a0 wr ocw    irr    imr    pd lvl   oe data   ack
    row(1, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h5A, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h5A, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h33, 8'hF0, 0, 3'd0, 1, 8'h5A, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 1, 1, 0, 1, 8'h0B, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h21, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 1, 1, 0, 1, 8'h08, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h21, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // IMR read with sources changing mid-strobe
    row(0, 0, 0, 1, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'hF0, 0);
    row(0, 0, 0, 1, 0, 8'h00, 8'hFF, 8'hF0, 0, 3'd0, 1, 8'hF0, 0);
    row(0, 0, 0, 1, 0, 8'h00, 8'hFF, 8'h0F, 0, 3'd0, 1, 8'hF0, 0);
    row(0, 1, 1, 1, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // poll with pending request, then normal IMR read
    row(0, 1, 1, 0, 1, 8'h0C, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 1, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd5, 1, 8'h85, 1);
    row(0, 0, 0, 1, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd5, 1, 8'h85, 0);
    row(0, 1, 1, 1, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd5, 0, 8'h00, 0);
    row(0, 0, 0, 1, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd5, 1, 8'hF0, 0);
    row(0, 1, 1, 1, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // poll with nothing pending disarms without ack
    row(0, 1, 1, 0, 1, 8'h0C, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h00, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h21, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h21, 0);
    // reset during DRIVE with strobe held
    row(1, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // OCW3 on the capture edge: old selection (IRR after reset) used
    row(0, 0, 0, 0, 1, 8'h0B, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h5A, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 1, 8'h21, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 1, 8'h0C, 8'h5A, 8'hF0, 1, 3'd2, 1, 8'h21, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd2, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd2, 1, 8'h82, 1);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // poll write on a poll capture edge re-arms
    row(0, 1, 1, 0, 1, 8'h0C, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 0, 0, 0, 1, 8'h0C, 8'h5A, 8'hF0, 1, 3'd7, 1, 8'h87, 1);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd7, 0, 8'h00, 0);
    row(0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 1, 3'd1, 1, 8'h81, 1);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    // read strobe without chip select is ignored
    row(0, 1, 0, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);
    row(0, 1, 1, 0, 0, 8'h00, 8'h5A, 8'hF0, 0, 3'd0, 0, 8'h00, 0);

    In_Service_Reg = 8'h21;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; chip_select_n = vecs[i].cs_n; read_n = vecs[i].rd_n;
      A0 = vecs[i].a0; write_OCW_3 = vecs[i].wr; Internal_bus_data = vecs[i].ocw;
      Interrupt_Request_Reg = vecs[i].irr; Interrupt_Mask = vecs[i].imr;
      interrupt_pending = vecs[i].pend; highest_level = vecs[i].lvl;
      @(posedge clk); #1;
      check("vec_oe",   i, {7'd0, Data_bus_oe}, {7'd0, vecs[i].e_oe});
      check("vec_data", i, Data_bus_out, vecs[i].e_data);
      check("vec_ack",  i, {7'd0, poll_ack}, {7'd0, vecs[i].e_ack});
    end

    // Random phase against the reference model
    reset = 1'b1; chip_select_n = 1'b1; read_n = 1'b1; write_OCW_3 = 1'b0;
    @(posedge clk); model_edge(); #1;
    ack_in_read = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) read_n = ~read_n;
      chip_select_n = ($urandom_range(0, 7) == 0);
      A0 = $urandom_range(0, 1);
      write_OCW_3 = ($urandom_range(0, 5) == 0);
      Internal_bus_data = 8'h08 | 8'($urandom_range(0, 7));
      Interrupt_Mask = 8'($urandom);
      Interrupt_Request_Reg = 8'($urandom);
      In_Service_Reg = 8'($urandom);
      interrupt_pending = $urandom_range(0, 1);
      highest_level = 3'($urandom_range(0, 7));
      @(posedge clk);
      model_edge();
      #1;
      check("rnd_oe",   c, {7'd0, Data_bus_oe}, {7'd0, m_reading});
      check("rnd_data", c, Data_bus_out, m_reading ? m_word : 8'h00);
      check("rnd_ack",  c, {7'd0, poll_ack}, {7'd0, m_ack});
      if (!Data_bus_oe) ack_in_read = 0;
      else if (poll_ack) ack_in_read++;
      check("rnd_ack_once", c, 8'(ack_in_read > 1), 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
